// File: rtl/net_pkg.sv
// rtl/net_pkg.sv - shared state encoding and Ethernet constants for the net_up/net_down paths
package net_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RX      = 2'd1;
    localparam state_t ST_DISCARD = 2'd2;
    localparam state_t ST_NOTIFY  = 2'd3;

    localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0] SFD_BYTE        = 8'hD5;
    localparam int         ETH_MAX_RAW_LEN = 1526;

    // Longest run of non-SFD bytes tolerated before the frame is abandoned.
    localparam logic [3:0] PRE_MAX_BYTES   = 4'd15;

endpackage

// File: rtl/net_sync_l2h.sv
// rtl/net_sync_l2h.sv - 3-FF level synchronizer with a one-cycle rising-edge pulse
module net_sync_l2h (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr <= '0;
        end else begin
            sync_sr <= {sync_sr[1:0], async_in};
        end
    end

    // sync_sr[1] is the first metastability-safe stage; sync_sr[2] is its history.
    assign rise = sync_sr[1] & ~sync_sr[2];

endmodule

// File: rtl/net_up.sv
// rtl/net_up.sv - GMII RX frame capture into uplink RAM with start/len/completed handshake (option: NET_UP_PREAMBLE_STRIP_EN)
module net_up
    import net_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = ETH_MAX_RAW_LEN,
    parameter int MIN_LEN = 1,
    parameter int DROP_W  = 16
) (
    input  logic              clk_125m,
    input  logic              rst_n,
    input  logic [7:0]        gmii_rxd,
    input  logic              gmii_rxdv,
    input  logic              gmii_rxer,
    output logic              ram_net_up_wr_en,
    output logic              ram_net_up_wr_we,
    output logic [ADDR_W-1:0] ram_net_up_wr_addr,
    output logic [7:0]        ram_net_up_wr_data,
    output logic              ram_net_up_start,
    output logic [ADDR_W-1:0] ram_net_up_len,
    input  logic              ram_net_up_completed,
    output logic [DROP_W-1:0] net_up_drop_cnt
);

    // One spare bit so a MAX_LEN of 2**ADDR_W still compares correctly.
    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LEN);

    logic [7:0]       rxd_q;
    logic             rxdv_q;
    logic             rxdv_qq;
    logic             rxer_q;
    logic             primed;
    logic             armed;
    logic             sof;
    logic             eof;
    logic             done_l2h;
    logic             frame_ok;
    logic             drop_evt;
    state_t           state;
    logic [CNT_W-1:0] cnt;
`ifdef NET_UP_PREAMBLE_STRIP_EN
    logic             sfd_seen;
    logic [3:0]       pre_cnt;
`endif

    net_sync_l2h u_sync_completed (
        .clk      (clk_125m),
        .rst_n    (rst_n),
        .async_in (ram_net_up_completed),
        .rise     (done_l2h)
    );

    // primed keeps the reset value of rxdv_q from arming us while a frame is already on the wire.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q   <= '0;
            rxdv_q  <= 1'b0;
            rxdv_qq <= 1'b0;
            rxer_q  <= 1'b0;
            primed  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            rxd_q   <= gmii_rxd;
            rxdv_q  <= gmii_rxdv;
            rxdv_qq <= rxdv_q;
            rxer_q  <= gmii_rxer;
            primed  <= 1'b1;
            if (primed && !rxdv_q) begin
                armed <= 1'b1;
            end
        end
    end

    assign sof = rxdv_q & ~rxdv_qq;
    assign eof = ~rxdv_q & rxdv_qq;

`ifdef NET_UP_PREAMBLE_STRIP_EN
    assign frame_ok = sfd_seen && (cnt >= MIN_CNT);
`else
    assign frame_ok = (cnt >= MIN_CNT);
`endif

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            drop_evt           <= 1'b0;
            ram_net_up_wr_en   <= 1'b0;
            ram_net_up_wr_we   <= 1'b0;
            ram_net_up_wr_addr <= '0;
            ram_net_up_wr_data <= '0;
            ram_net_up_start   <= 1'b0;
            ram_net_up_len     <= '0;
`ifdef NET_UP_PREAMBLE_STRIP_EN
            sfd_seen           <= 1'b0;
            pre_cnt            <= '0;
`endif
        end else begin
            ram_net_up_wr_en <= 1'b0;
            ram_net_up_wr_we <= 1'b0;
            drop_evt         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (sof && armed) begin
                        if (rxer_q) begin
                            state <= ST_DISCARD;
                        end else begin
                            state <= ST_RX;
`ifdef NET_UP_PREAMBLE_STRIP_EN
                            cnt      <= '0;
                            sfd_seen <= (rxd_q == SFD_BYTE);
                            pre_cnt  <= (rxd_q == SFD_BYTE) ? 4'd0 : 4'd1;
`else
                            ram_net_up_wr_en   <= 1'b1;
                            ram_net_up_wr_we   <= 1'b1;
                            ram_net_up_wr_addr <= '0;
                            ram_net_up_wr_data <= rxd_q;
                            cnt                <= CNT_W'(1);
`endif
                        end
                    end
                end

                ST_RX: begin
                    if (eof) begin
                        if (frame_ok) begin
                            ram_net_up_len   <= cnt[ADDR_W-1:0];
                            ram_net_up_start <= 1'b1;
                            state            <= ST_NOTIFY;
                        end else begin
                            drop_evt <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end else if (rxdv_q) begin
                        if (rxer_q) begin
                            state <= ST_DISCARD;
`ifdef NET_UP_PREAMBLE_STRIP_EN
                        end else if (!sfd_seen) begin
                            if (rxd_q == SFD_BYTE) begin
                                sfd_seen <= 1'b1;
                            end else if (pre_cnt == PRE_MAX_BYTES) begin
                                state <= ST_DISCARD;
                            end else begin
                                pre_cnt <= pre_cnt + 4'd1;
                            end
`endif
                        end else if (cnt == MAX_CNT) begin
                            state <= ST_DISCARD;
                        end else begin
                            ram_net_up_wr_en   <= 1'b1;
                            ram_net_up_wr_we   <= 1'b1;
                            ram_net_up_wr_addr <= cnt[ADDR_W-1:0];
                            ram_net_up_wr_data <= rxd_q;
                            cnt                <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_DISCARD: begin
                    if (eof) begin
                        drop_evt <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                ST_NOTIFY: begin
                    // A frame starting here is lost even if the consumer releases us this cycle.
                    if (sof) begin
                        drop_evt <= 1'b1;
                    end
                    if (done_l2h) begin
                        ram_net_up_start <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            net_up_drop_cnt <= '0;
        end else if (drop_evt && (net_up_drop_cnt != '1)) begin
            net_up_drop_cnt <= net_up_drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_net_up.sv
// tb/tb_net_up.sv - directed self-checking bench for net_up
module tb_net_up;

    logic        clk_125m = 1'b0;
    logic        rst_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rxdv;
    logic        gmii_rxer;
    logic        ram_net_up_wr_en;
    logic        ram_net_up_wr_we;
    logic [10:0] ram_net_up_wr_addr;
    logic [7:0]  ram_net_up_wr_data;
    logic        ram_net_up_start;
    logic [10:0] ram_net_up_len;
    logic        ram_net_up_completed;
    logic [15:0] net_up_drop_cnt;

    always #4 clk_125m = ~clk_125m;

    net_up dut (
        .clk_125m             (clk_125m),
        .rst_n                (rst_n),
        .gmii_rxd             (gmii_rxd),
        .gmii_rxdv            (gmii_rxdv),
        .gmii_rxer            (gmii_rxer),
        .ram_net_up_wr_en     (ram_net_up_wr_en),
        .ram_net_up_wr_we     (ram_net_up_wr_we),
        .ram_net_up_wr_addr   (ram_net_up_wr_addr),
        .ram_net_up_wr_data   (ram_net_up_wr_data),
        .ram_net_up_start     (ram_net_up_start),
        .ram_net_up_len       (ram_net_up_len),
        .ram_net_up_completed (ram_net_up_completed),
        .net_up_drop_cnt      (net_up_drop_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_total = 0;
    int t_sof    = 0;

    logic [10:0] log_addr [0:8191];
    logic [7:0]  log_data [0:8191];
    int          log_cyc  [0:8191];
    logic [7:0]  fbuf     [0:2047];

    always @(posedge clk_125m) cyc <= cyc + 1;

    always @(negedge clk_125m) begin
        if (ram_net_up_wr_en && ram_net_up_wr_we && wr_total < 8192) begin
            log_addr[wr_total] <= ram_net_up_wr_addr;
            log_data[wr_total] <= ram_net_up_wr_data;
            log_cyc[wr_total]  <= cyc;
            wr_total           <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int n, input int err_idx);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_125m); #1;
            gmii_rxd  = fbuf[i];
            gmii_rxdv = 1'b1;
            gmii_rxer = (i == err_idx);
            if (i == 0) t_sof = cyc;
        end
        @(posedge clk_125m); #1;
        gmii_rxdv = 1'b0;
        gmii_rxer = 1'b0;
        gmii_rxd  = 8'h00;
    endtask

    task automatic fill(input int n, input int mul, input int add);
        for (int i = 0; i < n; i++) fbuf[i] = 8'((i * mul + add) & 255);
    endtask

    task automatic wait_start(input logic lvl, input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_125m);
            if (ram_net_up_start === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int base, input int n, input int off);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (int'(log_addr[base + i]) != i || log_data[base + i] !== fbuf[off + i]) errs++;
        end
        check({tag, "_content"}, 32'(errs), 32'd0);
        check({tag, "_writes"}, 32'(wr_total - base), 32'(n));
    endtask

    task automatic complete(input string tag);
        logic ok;
        @(posedge clk_125m); #1;
        ram_net_up_completed = 1'b1;
        wait_start(1'b0, 6, ok);
        check({tag, "_release"}, 32'(ok), 32'd1);
        @(posedge clk_125m); #1;
        ram_net_up_completed = 1'b0;
        repeat (4) @(posedge clk_125m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   base;

        rst_n                = 1'b0;
        gmii_rxd             = 8'h00;
        gmii_rxdv            = 1'b0;
        gmii_rxer            = 1'b0;
        ram_net_up_completed = 1'b0;
        repeat (3) @(posedge clk_125m);
        #1;
        check("rst_start", 32'(ram_net_up_start), 32'd0);
        check("rst_len", 32'(ram_net_up_len), 32'd0);
        check("rst_drop", 32'(net_up_drop_cnt), 32'd0);
        check("rst_wr_en", 32'(ram_net_up_wr_en), 32'd0);
        check("rst_wr_we", 32'(ram_net_up_wr_we), 32'd0);
        check("rst_wr_addr", 32'(ram_net_up_wr_addr), 32'd0);
        check("rst_wr_data", 32'(ram_net_up_wr_data), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk_125m);

`ifdef NET_UP_PREAMBLE_STRIP_EN
        for (int i = 0; i < 7; i++) fbuf[i] = 8'h55;
        fbuf[7] = 8'hD5;
        for (int i = 8; i < 68; i++) fbuf[i] = 8'(((i - 8) * 3 + 1) & 255);
        base = wr_total;
        send_frame(68, -1);
        wait_start(1'b1, 6, ok);
        check("pre_start", 32'(ok), 32'd1);
        check("pre_len", 32'(ram_net_up_len), 32'd60);
        check("pre_first_data", 32'(log_data[base]), 32'd1);
        check_frame("pre", base, 60, 8);
        complete("pre");

        for (int i = 0; i < 10; i++) fbuf[i] = 8'h55;
        send_frame(10, -1);
        repeat (6) @(negedge clk_125m);
        check("nosfd_short_start", 32'(ram_net_up_start), 32'd0);
        check("nosfd_short_drop", 32'(net_up_drop_cnt), 32'd1);

        for (int i = 0; i < 20; i++) fbuf[i] = 8'h55;
        base = wr_total;
        send_frame(20, -1);
        repeat (6) @(negedge clk_125m);
        check("nosfd_long_drop", 32'(net_up_drop_cnt), 32'd2);
        check("nosfd_long_writes", 32'(wr_total - base), 32'd0);
`else
        // 64-byte ramp: data == address, check pin-to-RAM latency too.
        fill(64, 1, 0);
        base = wr_total;
        send_frame(64, -1);
        wait_start(1'b1, 6, ok);
        check("a_start", 32'(ok), 32'd1);
        check("a_len", 32'(ram_net_up_len), 32'd64);
        check_frame("a", base, 64, 0);
        check("a_latency", 32'(log_cyc[base] - t_sof), 32'd2);
        check("a_drop", 32'(net_up_drop_cnt), 32'd0);
        complete("a");

        // rxer on byte 20 of a 100-byte frame.
        fill(100, 7, 3);
        send_frame(100, 20);
        repeat (6) @(negedge clk_125m);
        check("err_start", 32'(ram_net_up_start), 32'd0);
        check("err_drop", 32'(net_up_drop_cnt), 32'd1);
        fill(64, 1, 0);
        base = wr_total;
        send_frame(64, -1);
        wait_start(1'b1, 6, ok);
        check("b_start", 32'(ok), 32'd1);
        check("b_len", 32'(ram_net_up_len), 32'd64);
        check_frame("b", base, 64, 0);
        complete("b");

        // 1600-byte oversize frame.
        fill(1600, 13, 5);
        base = wr_total;
        send_frame(1600, -1);
        repeat (6) @(negedge clk_125m);
        check("over_writes", 32'(wr_total - base), 32'd1526);
        check("over_last_addr", 32'(log_addr[base + 1525]), 32'd1525);
        check("over_start", 32'(ram_net_up_start), 32'd0);
        check("over_drop", 32'(net_up_drop_cnt), 32'd2);

        // Second frame while start is held.
        fill(64, 1, 0);
        send_frame(64, -1);
        wait_start(1'b1, 6, ok);
        check("c_start", 32'(ok), 32'd1);
        fill(30, 11, 9);
        base = wr_total;
        send_frame(30, -1);
        repeat (6) @(negedge clk_125m);
        check("busy_writes", 32'(wr_total - base), 32'd0);
        check("busy_drop", 32'(net_up_drop_cnt), 32'd3);
        check("busy_len", 32'(ram_net_up_len), 32'd64);
        check("busy_start", 32'(ram_net_up_start), 32'd1);
        complete("c");
        fill(40, 5, 1);
        base = wr_total;
        send_frame(40, -1);
        wait_start(1'b1, 6, ok);
        check("e_start", 32'(ok), 32'd1);
        check("e_len", 32'(ram_net_up_len), 32'd40);
        check_frame("e", base, 40, 0);
        complete("e");

        // Exactly MAX_LEN bytes is a legal frame.
        fill(1526, 3, 7);
        base = wr_total;
        send_frame(1526, -1);
        wait_start(1'b1, 6, ok);
        check("max_start", 32'(ok), 32'd1);
        check("max_len", 32'(ram_net_up_len), 32'd1526);
        check("max_writes", 32'(wr_total - base), 32'd1526);
        check("max_drop", 32'(net_up_drop_cnt), 32'd3);

        // SOF and completed edge land on the same FSM cycle.
        @(posedge clk_125m); #1;
        ram_net_up_completed = 1'b1;
        base = wr_total;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_125m); #1;
            gmii_rxd  = 8'(i);
            gmii_rxdv = 1'b1;
        end
        @(posedge clk_125m); #1;
        gmii_rxdv = 1'b0;
        repeat (6) @(negedge clk_125m);
        check("coinc_start", 32'(ram_net_up_start), 32'd0);
        check("coinc_drop", 32'(net_up_drop_cnt), 32'd4);
        check("coinc_writes", 32'(wr_total - base), 32'd0);
        @(posedge clk_125m); #1;
        ram_net_up_completed = 1'b0;
        repeat (4) @(posedge clk_125m);
`endif

        // Reset during NOTIFY with a frame on the wire, released mid-frame.
        fill(64, 1, 0);
        send_frame(64, -1);
        wait_start(1'b1, 6, ok);
        check("g_start", 32'(ok), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_125m); #1;
            gmii_rxd  = 8'(i + 100);
            gmii_rxdv = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(ram_net_up_start), 32'd0);
        check("mid_rst_drop", 32'(net_up_drop_cnt), 32'd0);
        @(posedge clk_125m); #1;
        rst_n = 1'b1;
        base = wr_total;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_125m); #1;
            gmii_rxd  = 8'(i + 150);
            gmii_rxdv = 1'b1;
        end
        @(posedge clk_125m); #1;
        gmii_rxdv = 1'b0;
        repeat (6) @(negedge clk_125m);
        check("inflight_writes", 32'(wr_total - base), 32'd0);
        check("inflight_start", 32'(ram_net_up_start), 32'd0);
`ifdef NET_UP_PREAMBLE_STRIP_EN
        for (int i = 0; i < 7; i++) fbuf[i] = 8'h55;
        fbuf[7] = 8'hD5;
        for (int i = 8; i < 72; i++) fbuf[i] = 8'(i - 8);
        base = wr_total;
        send_frame(72, -1);
        wait_start(1'b1, 6, ok);
        check("h_start", 32'(ok), 32'd1);
        check("h_len", 32'(ram_net_up_len), 32'd64);
        check_frame("h", base, 64, 8);
`else
        fill(64, 1, 0);
        base = wr_total;
        send_frame(64, -1);
        wait_start(1'b1, 6, ok);
        check("h_start", 32'(ok), 32'd1);
        check("h_len", 32'(ram_net_up_len), 32'd64);
        check_frame("h", base, 64, 0);
`endif
        complete("h");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
